// File: rtl/nco_iq_upconverter.sv
// nco_iq_upconverter
//   Quadrature upconverter behind the NCO. Computes s = I*cos - Q*sin from the
//   NCO sine/cosine and a held baseband I/Q pair. Rounds (half toward +inf),
//   shifts right by SHIFT and saturates to a 14-bit DAC sample. The datapath is
//   three register stages deep. A run/drain FSM gates sample admission, and a
//   sticky saturation counter is provided for bring-up.
//
//   Build option: define IQ_UPCONV_OFFSET_BIN_EN to emit offset-binary samples
//   (zero code 14'h2000). Otherwise samples are two's complement (zero code 14'h0000).
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   enable_i     run request (level)
//   clear_i      synchronous clear of sat_count_o
//   fsin_i       NCO sine, 13-bit signed
//   fcos_i       NCO cosine, 13-bit signed
//   nco_valid_i  qualifies fsin_i/fcos_i
//   bb_i_i       baseband I, 13-bit signed
//   bb_q_i       baseband Q, 13-bit signed
//   bb_valid_i   loads the baseband hold registers
//   dac_o        passband sample, forced to the zero code when not valid
//   out_valid_o  qualifies dac_o
//   busy_o       high in RUN or DRAIN
//   sat_count_o  saturation event count, sticks at 16'hFFFF

module nco_iq_upconverter #(
    parameter int unsigned SHIFT = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic signed [12:0] fsin_i,
    input  logic signed [12:0] fcos_i,
    input  logic               nco_valid_i,
    input  logic signed [12:0] bb_i_i,
    input  logic signed [12:0] bb_q_i,
    input  logic               bb_valid_i,
    output logic        [13:0] dac_o,
    output logic               out_valid_o,
    output logic               busy_o,
    output logic        [15:0] sat_count_o
);

`ifdef IQ_UPCONV_OFFSET_BIN_EN
    localparam logic [13:0] ZeroCode = 14'h2000;
`else
    localparam logic [13:0] ZeroCode = 14'h0000;
`endif

    localparam logic signed [27:0] RoundBias = 28'sd1 <<< (SHIFT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e state_q;
    logic [1:0] drain_cnt_q;

    logic signed [12:0] hold_i_q, hold_q_q;

    logic               s1_valid_q;
    logic signed [12:0] s1_sin_q, s1_cos_q, s1_i_q, s1_q_q;
    logic               s2_valid_q;
    logic signed [25:0] s2_pi_q, s2_pq_q;

    logic               admit;
    logic signed [27:0] sum_ext, rounded, shifted;
    logic               sat_hi, sat_lo, sat;
    logic signed [13:0] sat_r;
    logic        [13:0] code;

    assign admit  = nco_valid_i && (state_q == StRun);
    assign busy_o = (state_q != StIdle);

    // Baseband hold, loadable in any state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_i_q <= '0;
            hold_q_q <= '0;
        end else if (bb_valid_i) begin
            hold_i_q <= bb_i_i;
            hold_q_q <= bb_q_i;
        end
    end

    // Run/drain control; DRAIN lasts exactly three cycles and ignores enable_i.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable_i) state_q <= StRun;
                end
                StRun: begin
                    if (!enable_i) begin
                        state_q     <= StDrain;
                        drain_cnt_q <= '0;
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == 2'd2) state_q <= StIdle;
                    else drain_cnt_q <= drain_cnt_q + 2'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stages 1 and 2: capture, then full-precision products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sin_q   <= '0;
            s1_cos_q   <= '0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_pi_q    <= '0;
            s2_pq_q    <= '0;
        end else begin
            s1_valid_q <= admit;
            s1_sin_q   <= fsin_i;
            s1_cos_q   <= fcos_i;
            s1_i_q     <= hold_i_q;
            s1_q_q     <= hold_q_q;
            s2_valid_q <= s1_valid_q;
            s2_pi_q    <= s1_i_q * s1_cos_q;
            s2_pq_q    <= s1_q_q * s1_sin_q;
        end
    end

    // Stage 3 arithmetic. 28 bits leave headroom for the rounding bias at any legal SHIFT.
    always_comb begin
        sum_ext = $signed({{2{s2_pi_q[25]}}, s2_pi_q}) - $signed({{2{s2_pq_q[25]}}, s2_pq_q});
        rounded = sum_ext + RoundBias;
        shifted = rounded >>> SHIFT;
        sat_hi  = (shifted > 28'sd8191);
        sat_lo  = (shifted < -28'sd8192);
        sat     = sat_hi || sat_lo;
        if (sat_hi)      sat_r = 14'sh1FFF;
        else if (sat_lo) sat_r = 14'sh2000;
        else             sat_r = shifted[13:0];
`ifdef IQ_UPCONV_OFFSET_BIN_EN
        code = {~sat_r[13], sat_r[12:0]};
`else
        code = sat_r;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_o <= 1'b0;
            dac_o       <= ZeroCode;
            sat_count_o <= '0;
        end else begin
            out_valid_o <= s2_valid_q;
            dac_o       <= s2_valid_q ? code : ZeroCode;
            if (clear_i) begin
                sat_count_o <= '0;
            end else if (s2_valid_q && sat && (sat_count_o != 16'hFFFF)) begin
                sat_count_o <= sat_count_o + 16'd1;
            end
        end
    end

endmodule

// File: doc/nco_iq_upconverter.md
# nco_iq_upconverter

Quadrature upconverter that sits directly downstream of the NCO (nco91) on the DE4 ADA-HSMB datapath. It consumes the NCO's 13-bit signed sine/cosine samples and a held baseband I/Q pair, and computes the real passband sample s = I·cos − Q·sin. It rounds, scales and saturates the result to a 14-bit sample for the HSMB DAC. It provides a run/drain control FSM and a saturation counter for bring-up.

## Interface
- SHIFT, 12: arithmetic right shift applied to the 27-bit sum before saturation; legal range 10..14.
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable_i  in  1  run request (level).
- clear_i  in  1  synchronous clear of sat_count_o (one-cycle pulse).
- fsin_i  in  13  NCO sine, two's complement.
- fcos_i  in  13  NCO cosine, two's complement.
- nco_valid_i  in  1  NCO out_valid; qualifies fsin_i/fcos_i.
- bb_i_i  in  13  baseband I, two's complement.
- bb_q_i  in  13  baseband Q, two's complement.
- bb_valid_i  in  1  loads bb_i_i/bb_q_i into hold registers.
- dac_o  out  14  passband sample (format per Configuration).
- out_valid_o  out  1  qualifies dac_o.
- busy_o  out  1  high in RUN or DRAIN.
- sat_count_o  out  16  saturation event count, sticks at 16'hFFFF.

## Operation
- Baseband hold: I_h/Q_h load on any cycle with bb_valid_i, in any state; reset value 0. No backpressure.
- FSM states: IDLE, RUN, DRAIN.
- IDLE → RUN when enable_i=1.
- RUN → DRAIN when enable_i=0.
- DRAIN → IDLE after exactly 3 cycles. enable_i is ignored during DRAIN.
- Pipeline admission: a sample enters the pipeline iff nco_valid_i=1 and state=RUN.
- Stage 1: register fsin, fcos, I_h, Q_h and valid.
- Stage 2: register pI = I·cos and pQ = Q·sin, each 26-bit signed full precision.
- Stage 3: sum = pI − pQ (27-bit signed). r = (sum + 2^(SHIFT−1)) >>> SHIFT, i.e. round half toward +∞.
  - Saturate r to [−8192, 8191].
  - On a saturated valid sample, increment sat_count_o (no wrap).
- When out_valid_o=0, dac_o is forced to the zero code.
- clear_i and a saturation event in the same cycle: clear wins, count becomes 0.
- Reset mid-operation: state goes to IDLE immediately, pipeline valids cleared, all outputs take reset values.

## Timing
- Latency: 3 clk from the admitted input edge to out_valid_o/dac_o.
- Throughput: one sample per clk.
- Gaps in nco_valid_i (clken low upstream) propagate as out_valid_o gaps, with no reordering.
- Samples admitted in the last RUN cycle emerge during DRAIN. busy_o stays high until the IDLE transition.
- Reset values:
  - dac_o = zero code.
  - out_valid_o = 0.
  - busy_o = 0.
  - sat_count_o = 0.
  - FSM = IDLE.
- Zero code is 14'h0000 (two's complement) or 14'h2000 (offset binary).

## Configuration
- IQ_UPCONV_OFFSET_BIN_EN defined: dac_o = saturated r + 8192, i.e. MSB inverted, offset binary for the HSMB DAC. Zero code is 14'h2000.
- Not defined: dac_o is the saturated r in two's complement. Zero code is 14'h0000.

## Test plan
- Basic path (SHIFT=12, macro off): bb_i=4095, bb_q=0, fcos=4095, fsin=0, enable=1.
  - dac_o=4094 exactly 3 clk after admission, out_valid_o=1.
  - With macro on: dac_o=12286.
- Quadrature sign: bb_i=0, bb_q=2048, fsin=2048, fcos=0.
  - dac_o=−1024 (14'h3C00).
  - sat_count_o unchanged.
- Saturation (SHIFT=11): bb_i=−4096, fcos=−4096, bb_q=−4096, fsin=4095.
  - dac_o=8191.
  - sat_count_o increments by 1 per sample.
  - A clear_i pulse in the same cycle as a saturation event yields 0.
- Drain: continuous nco_valid_i, enable_i dropped at cycle N.
  - Last valid output at N+3.
  - busy_o falls after the 3 DRAIN cycles.
  - dac_o returns to the zero code.
- Gapped NCO: nco_valid_i pattern 1,0,1,1,0 in RUN → out_valid_o shows 1,0,1,1,0 delayed by 3 clk.
- Async reset mid-RUN: assert reset between clk edges.
  - out_valid_o, busy_o and sat_count_o go to 0 and dac_o to the zero code immediately.
  - After release with enable_i=1, the FSM re-enters RUN.
